// File: rtl/rgb_channel_splitter_pkg.sv
// rtl/rgb_channel_splitter_pkg.sv - shared types and constants for the RGB channel splitter
package rgb_channel_splitter_pkg;

    // Which colour word of the current pixel is expected next
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_D          = 9;

    // Width of a counter that must reach t-1; never narrower than one bit
    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/rgb_channel_splitter.sv
// rtl/rgb_channel_splitter.sv - splits an interleaved R,G,B word stream into parallel pixels (optional: RGB_SPLIT_SYNC_CHECK_EN)
module rgb_channel_splitter
    import rgb_channel_splitter_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int D          = DEFAULT_D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_sof,
    input  logic                  hold,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic [data_width-1:0] pxl_out_1,
    output logic [data_width-1:0] pxl_out_2,
    output logic [data_width-1:0] pxl_out_3,
    output logic                  frame_end,
    output logic                  sync_err
);

    localparam int T  = D * D;
    localparam int CW = cnt_width(T);
    localparam logic [CW-1:0] LAST_PIX = CW'(T - 1);

    phase_t                phase;
    logic                  pending;
    logic [CW-1:0]         count;
    logic [data_width-1:0] r_hold;
    logic [data_width-1:0] g_hold;
    logic                  strobe;
    logic                  accept;
    logic                  sof_take;
    logic                  sync_err_q;

    // A finished triple is presented as soon as the downstream is not pausing
    assign strobe      = pending & ~hold;
    assign valid_out_1 = strobe;
    assign valid_out_2 = strobe;
    assign valid_out_3 = strobe;

    // Only stall upstream when a triple is stuck behind hold; a B word then could not be stored
    assign s_ready = ~(pending & hold);
    assign accept  = s_valid & s_ready;

`ifdef RGB_SPLIT_SYNC_CHECK_EN
    assign sof_take = accept & s_sof;
    assign sync_err = sync_err_q;
`else
    logic unused_sof;
    assign unused_sof = s_sof;
    assign sof_take   = 1'b0;
    assign sync_err   = 1'b0;
`endif

    // A resync word restarts the frame, so a strobe sharing its cycle cannot close the frame
    assign frame_end = strobe & (count == LAST_PIX) & ~sof_take;

    // Phase FSM, holding registers, output triple, pending flag and pixel counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= PH_R;
            pending    <= 1'b0;
            count      <= '0;
            r_hold     <= '0;
            g_hold     <= '0;
            pxl_out_1  <= '0;
            pxl_out_2  <= '0;
            pxl_out_3  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            if (strobe) begin
                pending <= 1'b0;
                if (!sof_take) begin
                    count <= (count == LAST_PIX) ? '0 : count + 1'b1;
                end
            end
            if (sof_take) begin
                r_hold <= s_data;
                phase  <= PH_G;
                count  <= '0;
                if ((phase != PH_R) || (count != '0)) begin
                    sync_err_q <= 1'b1;
                end
            end else if (accept) begin
                case (phase)
                    PH_R: begin
                        r_hold <= s_data;
                        phase  <= PH_G;
                    end
                    PH_G: begin
                        g_hold <= s_data;
                        phase  <= PH_B;
                    end
                    PH_B: begin
                        pxl_out_1 <= r_hold;
                        pxl_out_2 <= g_hold;
                        pxl_out_3 <= s_data;
                        pending   <= 1'b1;
                        phase     <= PH_R;
                    end
                    default: phase <= PH_R;
                endcase
            end
        end
    end

endmodule

// File: doc/rgb_channel_splitter.md
RGB_CHANNEL_SPLITTER -- requirements
Module: rgb_channel_splitter

Interface
REQ-001 Parameter data_width, default 32: width in bits of every pixel word.
REQ-002 Parameter D, default 9: frame is D x D pixels, so T = D*D pixels per frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  an upstream word is present on s_data.
REQ-006 s_ready  output  1  block accepts the word this cycle; a transfer occurs when s_valid and s_ready are both 1.
REQ-007 s_data  input  data_width  interleaved channel word, sent in the order R, G, B per pixel.
REQ-008 s_sof  input  1  marks the R word of pixel 0 of a frame.
REQ-009 hold  input  1  downstream pause request.
REQ-010 valid_out_1, valid_out_2, valid_out_3  output  1 each  channel strobes; always equal to each other.
REQ-011 pxl_out_1, pxl_out_2, pxl_out_3  output  data_width each  R, G and B pixel values.
REQ-012 frame_end  output  1  pulses together with the strobe of pixel T-1.
REQ-013 sync_err  output  1  sticky resynchronisation flag.

Function
REQ-014 The phase FSM has three states: PH_R -> PH_G -> PH_B -> PH_R; the state advances only on an accepted word.
- In PH_R and PH_G the accepted word is captured into the r_hold or g_hold register.
- In PH_B the accepted word, r_hold and g_hold are loaded into pxl_out_1, pxl_out_2 and pxl_out_3, and the pending flag is set.
REQ-015 valid_out_1/2/3 = pending & ~hold; pending clears on the cycle the strobe is asserted.
- Latency: the strobe appears 1 cycle after B is accepted when hold = 0.
REQ-016 s_ready = ~(pending & hold).
- An accepted B word while pending is set and hold = 0 is legal: the old triple strobes this cycle and the new triple loads, so throughput is 1 pixel per 3 words with no bubble.
REQ-017 pxl_out_1/2/3 hold their values when no new triple loads and while hold = 1; no strobe is dropped or duplicated.
REQ-018 The pixel counter (width ceil(log2(T))) increments on each strobe.
- frame_end = strobe & (count == T-1).
- The counter wraps from T-1 to 0 on that strobe.
REQ-019 If hold and a B acceptance would coincide with pending = 1, s_ready = 0 blocks the acceptance, so the B word is never lost.

Reset
REQ-020 While reset = 0:
- Phase = PH_R, pending = 0, counter = 0.
- r_hold, g_hold and pxl_out_1..3 = 0.
- All strobes, frame_end and sync_err = 0; s_ready = 1.
REQ-021 Reset asserted mid-pixel or mid-frame discards the partial pixel and any pending triple; no strobe is emitted after deassertion until a full R, G, B triple is accepted.

Configuration
REQ-022 With RGB_SPLIT_SYNC_CHECK_EN defined:
- An accepted word with s_sof = 1 is treated as R of pixel 0: it is captured into r_hold, phase -> PH_G, counter -> 0.
- If that word arrived while phase != PH_R or counter != 0, sync_err is set and stays set until reset.
- A pending triple still strobes, but does not increment the counter and does not raise frame_end.
REQ-023 Without RGB_SPLIT_SYNC_CHECK_EN: s_sof is ignored and sync_err is tied to 0.

Structure
REQ-024 The shared package holds:
- the phase-state enumeration (PH_R, PH_G, PH_B);
- the default data_width = 32 and default D = 9 constants;
- the pixel-count width function.
REQ-025 The block is a single module with no sub-module; the FSM, holding registers and counter sit inline.

Verification
REQ-026 With D = 3, stream R,G,B = 0x11, 0x22, 0x33 with hold = 0:
- exactly 1 cycle later all three strobes = 1;
- pxl_out_1/2/3 = 0x11/0x22/0x33.
REQ-027 With D = 3, stream 9 full pixels back-to-back:
- 9 strobes;
- frame_end = 1 only on the 9th strobe;
- counter returns to 0.
REQ-028 Raise hold for 4 cycles while pending, then drive the next pixel's words:
- strobes stay 0 and s_ready = 0 while hold = 1;
- after hold drops, exactly one strobe carries the original values, followed by the next pixel.
REQ-029 Assert reset after the G word of pixel 5:
- all outputs read 0;
- the next strobe occurs only after a fresh R, G, B triple and carries count 0.
REQ-030 With RGB_SPLIT_SYNC_CHECK_EN defined, assert s_sof on a word in PH_B:
- sync_err = 1;
- phase -> PH_G, with that word captured as R;
- the following pixel strobes with count 0.
REQ-031 Without RGB_SPLIT_SYNC_CHECK_EN, run the same stimulus:
- sync_err stays 0;
- the word is treated as B and strobes normally.
